// File: rtl/key_sched_seq.sv
// AES key-expansion word-index sequencer: walks i over the expansion range for
// AES-128/192/256 and streams per-word control (i mod Nk, RotWord/SubWord, Rcon).
module key_sched_seq #(
  parameter int unsigned IDX_W         = 6,
  parameter int unsigned START_AT_ZERO = 0,
  parameter int unsigned RCON_EN       = 1
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic [1:0]       conf_in,
  input  logic             abort_in,
  input  logic             ready_in,
  output logic             valid_out,
  output logic [IDX_W-1:0] i_out,
  output logic [2:0]       imodk_out,
  output logic             rot_out,
  output logic             sub_out,
  output logic             init_out,
  output logic [7:0]       rcon_out,
  output logic             last_out,
  output logic             busy_out,
  output logic             done_out,
  output logic             err_out
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [3:0]       nk_q;
  logic [IDX_W-1:0] last_q;
  logic [7:0]       rcon_q;

  logic [3:0]       b_nk;
  logic [IDX_W-1:0] b_i;
  logic [IDX_W-1:0] b_last;
  logic [2:0]       b_imodk;
  logic [7:0]       b_rcon;
  logic [7:0]       xt;
  logic             b_init;
  logic             b_rot;
  logic             b_sub;
  logic             b_lastf;
  logic             wrap;
  logic             hs;

  // b_* is the beat to present next: the first beat when idle, else the successor.
  always_comb begin
    xt      = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
    wrap    = (imodk_out == 3'(nk_q - 4'd1));
    hs      = (state == RUN) && valid_out && ready_in;
    b_nk    = nk_q;
    b_last  = last_q;
    b_i     = i_out + IDX_W'(1);
    b_imodk = wrap ? '0 : imodk_out + 3'd1;
    b_rcon  = ((i_out >= IDX_W'(nk_q)) && wrap) ? xt : rcon_q;
    if (state == IDLE) begin
      case (conf_in)
        2'd0:    begin b_nk = 4'd4; b_last = IDX_W'(43); end
        2'd1:    begin b_nk = 4'd6; b_last = IDX_W'(51); end
        default: begin b_nk = 4'd8; b_last = IDX_W'(59); end
      endcase
      b_i     = (START_AT_ZERO != 0) ? '0 : IDX_W'(b_nk);
      b_imodk = '0;
      b_rcon  = 8'h01;
    end
    b_init  = (b_i < IDX_W'(b_nk));
    b_rot   = !b_init && (b_imodk == 3'd0);
    b_sub   = (b_nk == 4'd8) && !b_init && (b_imodk == 3'd4);
    b_lastf = (b_i == b_last);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state     <= IDLE;
      nk_q      <= '0;
      last_q    <= '0;
      rcon_q    <= 8'h01;
      valid_out <= 1'b0;
      i_out     <= '0;
      imodk_out <= '0;
      rot_out   <= 1'b0;
      sub_out   <= 1'b0;
      init_out  <= 1'b0;
      rcon_out  <= '0;
      last_out  <= 1'b0;
      busy_out  <= 1'b0;
      done_out  <= 1'b0;
      err_out   <= 1'b0;
    end else begin
      done_out <= 1'b0;
      err_out  <= 1'b0;
      if (abort_in) begin
        state     <= IDLE;
        valid_out <= 1'b0;
        busy_out  <= 1'b0;
        i_out     <= '0;
        imodk_out <= '0;
        rot_out   <= 1'b0;
        sub_out   <= 1'b0;
        init_out  <= 1'b0;
        rcon_out  <= '0;
        last_out  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_in && (conf_in != 2'd3)) begin
              state     <= RUN;
              nk_q      <= b_nk;
              last_q    <= b_last;
              valid_out <= 1'b1;
              busy_out  <= 1'b1;
              i_out     <= b_i;
              imodk_out <= b_imodk;
              rcon_q    <= b_rcon;
              rcon_out  <= (RCON_EN != 0) ? b_rcon : '0;
              rot_out   <= b_rot;
              sub_out   <= b_sub;
              init_out  <= b_init;
              last_out  <= b_lastf;
            end else if (start_in) begin
              err_out <= 1'b1;
            end
          end
          RUN: begin
            if (hs && last_out) begin
              state     <= DONE;
              done_out  <= 1'b1;
              valid_out <= 1'b0;
              i_out     <= '0;
              imodk_out <= '0;
              rot_out   <= 1'b0;
              sub_out   <= 1'b0;
              init_out  <= 1'b0;
              rcon_out  <= '0;
              last_out  <= 1'b0;
            end else if (hs) begin
              i_out     <= b_i;
              imodk_out <= b_imodk;
              rcon_q    <= b_rcon;
              rcon_out  <= (RCON_EN != 0) ? b_rcon : '0;
              rot_out   <= b_rot;
              sub_out   <= b_sub;
              init_out  <= b_init;
              last_out  <= b_lastf;
            end
          end
          default: begin
            state    <= IDLE;
            busy_out <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_key_sched_seq.sv
// Self-checking bench for key_sched_seq: randomized back-pressure against a
// table-driven model of the AES key-expansion word sequence.
module tb_key_sched_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start0_in, start1_in;
  logic [1:0] conf_in;
  logic       abort_in;
  logic       ready_in;

  logic       v0, rot0, sub0, init0, last0, busy0, done0, err0;
  logic [5:0] i0;
  logic [2:0] m0;
  logic [7:0] rc0;
  logic       v1, rot1, sub1, init1, last1, busy1, done1, err1;
  logic [5:0] i1;
  logic [2:0] m1;
  logic [7:0] rc1;

  bit         sel;
  logic       o_valid, o_rot, o_sub, o_init, o_last, o_busy, o_done, o_err;
  logic [5:0] o_i;
  logic [2:0] o_m;
  logic [7:0] o_rc;

  int n_assert = 0;
  int n_fail   = 0;
  int cur_i    = -1;

  // Rcon by round number (index 0 unused)
  logic [7:0] rc_tab [0:10] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  always #5 clk = ~clk;

  key_sched_seq #(.IDX_W(6), .START_AT_ZERO(0), .RCON_EN(1)) dut0 (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start0_in), .conf_in(conf_in),
    .abort_in(abort_in), .ready_in(ready_in), .valid_out(v0), .i_out(i0),
    .imodk_out(m0), .rot_out(rot0), .sub_out(sub0), .init_out(init0),
    .rcon_out(rc0), .last_out(last0), .busy_out(busy0), .done_out(done0),
    .err_out(err0));

  key_sched_seq #(.IDX_W(6), .START_AT_ZERO(1), .RCON_EN(1)) dut1 (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start1_in), .conf_in(conf_in),
    .abort_in(abort_in), .ready_in(ready_in), .valid_out(v1), .i_out(i1),
    .imodk_out(m1), .rot_out(rot1), .sub_out(sub1), .init_out(init1),
    .rcon_out(rc1), .last_out(last1), .busy_out(busy1), .done_out(done1),
    .err_out(err1));

  assign o_valid = sel ? v1    : v0;
  assign o_i     = sel ? i1    : i0;
  assign o_m     = sel ? m1    : m0;
  assign o_rot   = sel ? rot1  : rot0;
  assign o_sub   = sel ? sub1  : sub0;
  assign o_init  = sel ? init1 : init0;
  assign o_rc    = sel ? rc1   : rc0;
  assign o_last  = sel ? last1 : last0;
  assign o_busy  = sel ? busy1 : busy0;
  assign o_done  = sel ? done1 : done0;
  assign o_err   = sel ? err1  : err0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s (i=%0d): observed %0h expected %0h", tag, cur_i, got, exp);
    end
  endtask

  task automatic drive_start(input logic s);
    if (sel) start1_in = s;
    else     start0_in = s;
  endtask

  // One full (or aborted) sequence on the selected instance.
  task automatic run_seq(input int conf, input int stall_pct, input int hold_i,
                         input int abort_at, input bit noise);
    int nk, lasti, first, n, k, ie, guard, hold_left;
    bit held;
    nk    = (conf == 0) ? 4 : (conf == 1) ? 6 : 8;
    lasti = 4 * (nk + 7) - 1;
    first = sel ? 0 : nk;
    n     = lasti - first + 1;
    conf_in = 2'(conf);
    drive_start(1'b1);
    ready_in = 1'b0;
    @(negedge clk);
    drive_start(1'b0);
    k = 0; guard = 0; hold_left = 0; held = 0;
    while (k < n && guard < 4000) begin
      ie    = first + k;
      cur_i = ie;
      chk("valid", 32'(o_valid), 32'd1);
      chk("busy",  32'(o_busy),  32'd1);
      chk("i",     32'(o_i),     32'(ie));
      chk("imodk", 32'(o_m),     32'(ie % nk));
      chk("rot",   32'(o_rot),   32'(ie >= nk && ie % nk == 0));
      chk("sub",   32'(o_sub),   32'(nk == 8 && ie >= nk && ie % nk == 4));
      chk("init",  32'(o_init),  32'(ie < nk));
      chk("rcon",  32'(o_rc),    32'((ie < nk) ? 8'h01 : rc_tab[ie / nk]));
      chk("last",  32'(o_last),  32'(ie == lasti));
      if (ie == abort_at) begin
        abort_in = 1'b1;
        ready_in = 1'($urandom_range(1));
        @(negedge clk);
        abort_in = 1'b0;
        ready_in = 1'b0;
        chk("abort_valid", 32'(o_valid), 32'd0);
        chk("abort_busy",  32'(o_busy),  32'd0);
        chk("abort_done",  32'(o_done),  32'd0);
        @(negedge clk);
        chk("abort_done2", 32'(o_done),  32'd0);
        chk("abort_valid2", 32'(o_valid), 32'd0);
        return;
      end
      if (ie == hold_i && !held) begin
        held = 1;
        hold_left = 3;
      end
      if (hold_left > 0) begin
        ready_in = 1'b0;
        hold_left--;
      end else begin
        ready_in = ($urandom_range(99) >= 32'(stall_pct));
      end
      if (noise) begin
        drive_start(1'($urandom_range(1)));
        conf_in = 2'($urandom_range(3));
      end
      @(negedge clk);
      if (ready_in) k++;
      guard++;
    end
    drive_start(1'b0);
    ready_in = 1'b0;
    cur_i = -1;
    chk("seq_in_budget", 32'(guard < 4000), 32'd1);
    chk("done_valid", 32'(o_valid), 32'd0);
    chk("done_pulse", 32'(o_done),  32'd1);
    chk("done_busy",  32'(o_busy),  32'd1);
    @(negedge clk);
    chk("idle_done",  32'(o_done),  32'd0);
    chk("idle_busy",  32'(o_busy),  32'd0);
    chk("idle_valid", 32'(o_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start0_in = 1'b0; start1_in = 1'b0; conf_in = '0;
    abort_in = 1'b0; ready_in = 1'b0; sel = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(v0), 32'd0);
    chk("rst_i",     32'(i0), 32'd0);
    chk("rst_rcon",  32'(rc0), 32'd0);
    chk("rst_busy",  32'(busy0 | busy1), 32'd0);
    chk("rst_flags", 32'({rot0, sub0, init0, last0, done0, err0}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_seq(0, 0, -1, -1, 0);    // AES-128 full rate
    run_seq(2, 30, -1, -1, 1);   // AES-256, stalls, ignored starts
    run_seq(1, 20, 10, -1, 0);   // AES-192, 3-cycle hold at i=10

    conf_in = 2'd3;
    start0_in = 1'b1;
    @(negedge clk);
    start0_in = 1'b0;
    chk("err_pulse", 32'(err0),  32'd1);
    chk("err_busy",  32'(busy0), 32'd0);
    chk("err_valid", 32'(v0),    32'd0);
    @(negedge clk);
    chk("err_clear", 32'(err0),  32'd0);
    chk("err_valid2", 32'(v0),   32'd0);
    chk("err_busy2", 32'(busy0), 32'd0);

    run_seq(0, 0, -1, 20, 0);    // abort at i=20
    run_seq(0, 25, -1, -1, 0);   // restart from i=4

    conf_in = 2'd1;
    start0_in = 1'b1;
    @(negedge clk);
    start0_in = 1'b0;
    ready_in = 1'b1;
    repeat (7) @(negedge clk);
    chk("prerst_valid", 32'(v0), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(v0),    32'd0);
    chk("arst_i",     32'(i0),    32'd0);
    chk("arst_busy",  32'(busy0), 32'd0);
    chk("arst_rcon",  32'(rc0),   32'd0);
    chk("arst_flags", 32'({m0, rot0, sub0, init0, last0, done0}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("postrst_valid", 32'(v0),    32'd0);
    chk("postrst_busy",  32'(busy0), 32'd0);
    ready_in = 1'b0;
    run_seq(1, 10, -1, -1, 0);

    sel = 1'b1;
    #1;
    run_seq(0, 0, -1, -1, 0);    // initial-key phase, AES-128
    run_seq(2, 40, -1, -1, 1);
    run_seq(1, 15, 3, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
